// File: rtl/instruction_loader.sv
// Packs decoded MIPS instruction fields big-endian and writes them one byte per
// clock into a byte-wide instruction memory image, advancing a base pointer per word.
module instruction_loader #(
    parameter  int unsigned size_ward = 2,
    parameter  int unsigned AW        = $clog2(size_ward*4),
    localparam int unsigned CW        = $clog2(size_ward+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    output logic          ready,
    input  logic [5:0]    op,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [4:0]    shamt,
    input  logic [5:0]    func,
    input  logic          clear,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic [CW-1:0] count,
    output logic          full
);

    localparam int unsigned BW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [BW-1:0] r_base;
    logic [BW-1:0] w_base_nxt;
    logic [1:0]    r_idx;
    logic [1:0]    w_idx_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [31:0]   r_word;
    logic [31:0]   w_word_nxt;
    logic          r_wr_en;
    logic          w_wr_en_nxt;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] w_wr_addr_nxt;
    logic [7:0]    r_wr_data;
    logic [7:0]    w_wr_data_nxt;
    logic          r_full;

    logic [31:0]   w_packed;
    logic [7:0]    w_byte_sel;

    assign w_packed = {op, rs, rt, rd, shamt, func};
    assign ready    = (r_state == IDLE) && !clear;

    always_comb begin
        w_byte_sel = r_word[31:24];
        case (r_idx)
            2'd1:    w_byte_sel = r_word[23:16];
            2'd2:    w_byte_sel = r_word[15:8];
            2'd3:    w_byte_sel = r_word[7:0];
            default: w_byte_sel = r_word[31:24];
        endcase
    end

    // Byte 0 is issued on the accept edge itself, so r_idx holds the index of the
    // next byte to emit; wrapping back to 0 in WRITE means all four bytes are out.
    always_comb begin
        w_state_nxt   = r_state;
        w_base_nxt    = r_base;
        w_idx_nxt     = r_idx;
        w_count_nxt   = r_count;
        w_word_nxt    = r_word;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        case (r_state)
            IDLE: begin
                if (clear) begin
                    w_base_nxt  = '0;
                    w_count_nxt = '0;
                end else if (valid) begin
                    w_word_nxt    = w_packed;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = AW'(r_base);
                    w_wr_data_nxt = w_packed[31:24];
                    w_idx_nxt     = 2'd1;
                    w_state_nxt   = WRITE;
                end
            end
            WRITE: begin
                if (r_idx == 2'd0) begin
                    w_base_nxt  = r_base + BW'(4);
                    w_count_nxt = r_count + CW'(1);
                    w_state_nxt = (w_count_nxt == CW'(size_ward)) ? FULL : IDLE;
                end else begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = AW'(r_base) + AW'(r_idx);
                    w_wr_data_nxt = w_byte_sel;
                    w_idx_nxt     = r_idx + 2'd1;
                end
            end
            FULL: begin
                if (clear) begin
                    w_base_nxt  = '0;
                    w_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_base    <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_word    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_full    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_base    <= w_base_nxt;
            r_idx     <= w_idx_nxt;
            r_count   <= w_count_nxt;
            r_word    <= w_word_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_full    <= (w_state_nxt == FULL);
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign count   = r_count;
    assign full    = r_full;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writes MIPS instructions, given as decoded fields, into the byte-wide instruction memory image. It is the write-side counterpart of the instruction memory read path. Each accepted instruction is packed big-endian into four bytes and written one byte per clock at consecutive addresses from an internal base pointer. It is used by boot/test logic to program the instruction store before execution.

## Interface

- `size_ward`, default 2: memory capacity in 32-bit instruction words. Byte depth is `size_ward*4`. Must be ≥1.
- `AW`, derived as `$clog2(size_ward*4)`: byte address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `valid`  in  1  instruction fields are presented this cycle.
- `ready`  out  1  loader can accept; combinational: `state==IDLE && !clear`.
- `op`  in  6  opcode field.
- `rs`  in  5  rs field.
- `rt`  in  5  rt field.
- `rd`  in  5  rd field.
- `shamt`  in  5  shamt field.
- `func`  in  6  function field.
- `clear`  in  1  rewind the base pointer to 0 and empty the word count.
- `wr_en`  out  1  byte write strobe to the memory, registered.
- `wr_addr`  out  AW  byte address, registered.
- `wr_data`  out  8  byte data, registered.
- `count`  out  `$clog2(size_ward+1)`  number of complete instructions written.
- `full`  out  1  memory holds `size_ward` instructions, registered.

## Operation

- **Packing** uses a 32-bit word `{op,rs,rt,rd,shamt,func}`:
  - byte0 = `{op, rs[4:3]}`
  - byte1 = `{rs[2:0], rt}`
  - byte2 = `{rd, shamt[4:2]}`
  - byte3 = `{shamt[1:0], func}`
- **States:** IDLE, WRITE, FULL.
- **IDLE:**
  - `valid && ready`: latch the packed word, set the byte index to 0, go to WRITE.
  - `clear`: base and count go to 0, stay in IDLE, and no accept occurs.
- **WRITE:**
  - One byte per cycle at `base+idx`, idx 0..3.
  - After idx 3: base += 4, count += 1.
  - If the new count equals `size_ward`, go to FULL, otherwise go to IDLE.
  - `clear` and `valid` are ignored in WRITE.
- **FULL:**
  - `ready` = 0 and `full` = 1; `valid` is ignored and no write occurs.
  - `clear` returns to IDLE with base and count at 0, and `full` drops.
- **Address arithmetic:** base is never incremented past `size_ward*4-4`, so there is no wrap. A base of `size_ward*4` only exists in the FULL condition.
- **Reset values:** state IDLE, base 0, idx 0, count 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `full` 0.
- **Reset mid-WRITE:** aborts the instruction. Bytes already written remain in memory, count is not incremented, and base returns to 0.

## Timing

- **Handshake** occurs on an edge where `valid && ready` is high. Fields need only be valid on that edge.
- **Byte strobes:** `wr_en` is high for exactly the 4 cycles following the accept edge, carrying bytes 0,1,2,3 in order. Address and data change together with `wr_en`.
- **Ready after a write:** `ready` is low for those 4 cycles. It returns high in the cycle after byte3, unless the loader is now FULL.
- **count/full update:** both update on the same edge that ends the byte3 cycle.
- **Throughput:** at most one instruction per 5 cycles.
- **Latency:** from accept edge to byte0 visible is 1 cycle; to last byte visible is 4 cycles.
- **Clear timing:** `clear` takes effect on the edge where it is sampled in IDLE or FULL. `ready` is already low in that same cycle.

## Test plan

- **Reset check:** hold `rst_n`=0 for 2 cycles with `valid`=1 -> `wr_en`=0, `wr_addr`=0, `wr_data`=0, `count`=0, `full`=0, and no accept.
- **Single instruction:** `size_ward`=2; accept op=0, rs=1, rt=2, rd=3, shamt=0, func=0x20 -> writes addr0=0x00, addr1=0x22, addr2=0x18, addr3=0x20 on 4 consecutive cycles; `count`=1; `ready` high on cycle 5.
- **All-ones fields:** second word op=0x23, rs=29, rt=8, rd=31, shamt=31, func=0x3F -> addr4=0x8F, addr5=0xA8, addr6=0xFF, addr7=0xFF; `count`=2; `full`=1; `ready`=0.
- **Valid while FULL:** `valid` held high for 10 cycles -> no `wr_en`, count stays 2. Then `clear` for 1 cycle -> `full`=0, `count`=0, and the next accept writes at addr0.
- **Ignored inputs in WRITE:** `clear` and `valid` pulsed during a WRITE -> ignored; all 4 bytes are written and count increments. `clear` together with `valid` in IDLE -> no accept, base 0.
- **Mid-write reset:** `rst_n` low during byte2 -> `wr_en` low from the next cycle, `count` unchanged at 0, and the next accept writes at addr0.
